// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared reset vector and instruction queue entry type for the fetch stage
package fetch_unit_pkg;
   localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } fetch_entry_t;
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: branch redirect, instruction memory and decode handshake signals of the fetch stage
interface fetch_unit_if;
   logic        jump_in;
   logic [31:0] jump_target;
   logic [31:0] instruction_address;
   logic        mem_req;
   logic [31:0] instruction_in;
   logic [31:0] instruction_out;
   logic [31:0] NPC_out;
   logic        valid_out;
   logic        ready_in;
   modport master (
      input  jump_in, jump_target, instruction_in, ready_in,
      output instruction_address, mem_req, instruction_out, NPC_out, valid_out
   );
   modport slave (
      output jump_in, jump_target, instruction_in, ready_in,
      input  instruction_address, mem_req, instruction_out, NPC_out, valid_out
   );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous FIFO of fetched {instr, pc} entries with flush and occupancy count
module fetch_queue
   import fetch_unit_pkg::*;
#(
   parameter int QDEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic                       flush_i,
   input  fetch_entry_t               din_i,
   output fetch_entry_t               head_o,
   output logic [$clog2(QDEPTH):0]    count_o
);
   localparam int AW = $clog2(QDEPTH);
   fetch_entry_t    mem_q [QDEPTH];
   logic [AW-1:0]   wr_q, rd_q;
   logic [AW:0]     cnt_q;
   // pointers and occupancy; a flush empties the queue regardless of push/pop
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else if (flush_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push_i) wr_q <= wr_q + AW'(1);
         if (pop_i) rd_q <= rd_q + AW'(1);
         cnt_q <= cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
      end
   end
   // entry storage; unreset because the count gates what is visible
   always_ff @(posedge clk) begin
      if (push_i && !flush_i) mem_q[wr_q] <= din_i;
   end
   assign head_o  = (cnt_q != '0) ? mem_q[rd_q] : '0;
   assign count_o = cnt_q;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner issuing credit-limited instruction reads, queueing returns and redirecting on jumps
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int          QDEPTH   = 4,
   parameter int          MEM_LAT  = 1,
   parameter logic [31:0] RESET_PC = RESET_VECTOR
) (
   input  logic         clk,
   input  logic         reset,
   fetch_unit_if.master bus
);
   localparam int CW = $clog2(QDEPTH) + 1;
   logic [31:0]                pc_q, pc_d;
   logic [MEM_LAT-1:0]         trk_v_q, trk_v_d;
   logic [MEM_LAT-1:0][31:0]   trk_pc_q, trk_pc_d;
   logic [CW-1:0]              count;
   logic [31:0]                inflight;
   logic                       issue, ret, pop;
   fetch_entry_t               din, head;
   assign inflight = 32'($countones(trk_v_q));
   assign issue    = reset && !bus.jump_in && ((32'(count) + inflight) < 32'(QDEPTH));
   assign ret      = trk_v_q[MEM_LAT-1] && !bus.jump_in;
   assign pop      = bus.valid_out && bus.ready_in;
   assign din      = {bus.instruction_in, trk_pc_q[MEM_LAT-1]};
   // next PC and tracker shift; a redirect overrides issue and kills every tracked read
   always_comb begin
      pc_d     = bus.jump_in ? {bus.jump_target[31:2], 2'b00} : issue ? pc_q + 32'd4 : pc_q;
      trk_v_d  = bus.jump_in ? '0 : MEM_LAT'({trk_v_q, issue});
      trk_pc_d = (MEM_LAT*32)'({trk_pc_q, pc_q});
   end
   // PC and in-flight tracker registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q     <= RESET_PC;
         trk_v_q  <= '0;
         trk_pc_q <= '0;
      end else begin
         pc_q     <= pc_d;
         trk_v_q  <= trk_v_d;
         trk_pc_q <= trk_pc_d;
      end
   end
   fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
      .clk     (clk),
      .reset   (reset),
      .push_i  (ret),
      .pop_i   (pop),
      .flush_i (bus.jump_in),
      .din_i   (din),
      .head_o  (head),
      .count_o (count)
   );
   assign bus.instruction_address = pc_q;
   assign bus.mem_req             = issue;
   assign bus.valid_out           = (count != '0) && !bus.jump_in;
   assign bus.instruction_out     = head.instr;
   assign bus.NPC_out             = head.pc;
endmodule
